// File: rtl/coin_pkg.sv
// coin_pkg: shared types and constants for the coin front end.
// Channel state encoding, debounce/jam defaults, and coin values for
// downstream credit logic.
package coin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARM     = 2'b01,
    ST_HOLD    = 2'b10,
    ST_RELEASE = 2'b11
  } chan_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 3;
  localparam int JAM_CYCLES_DEF      = 64;

  localparam int NICKEL_VALUE = 5;
  localparam int DIME_VALUE   = 10;

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: one sensor channel. Two-flop synchroniser, debounce FSM
// with a shared up-counter, and (with JAM_DETECT_EN defined) a jam timer
// that measures how long the coin sits in HOLD.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | slot empty, waiting for the synchronised line to go high
// ARM     | line high, counting toward acceptance; a low rejects it
// HOLD    | coin accepted (qualify fired once), waiting for release
// RELEASE | line low, counting toward idle; a high returns to HOLD
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
`ifdef JAM_DETECT_EN
  ,
  parameter int JAM_CYCLES      = JAM_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic qualify_o,
  output logic busy_o
`ifdef JAM_DETECT_EN
  ,
  output logic jam_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             s;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser for the asynchronous sensor line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;

  // State and debounce counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; the counter stops at CNT_LAST by construction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_ARM;
          cnt_d   = CNT_ONE;
        end
      end
      ST_ARM: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!s) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: qualify on the ARM->HOLD transition, busy whenever not idle
  always_comb begin
    qualify_o = (state_q == ST_ARM) && s && (cnt_q == CNT_LAST);
    busy_o    = (state_q != ST_IDLE);
  end

`ifdef JAM_DETECT_EN
  localparam int              JAM_W    = $clog2(JAM_CYCLES + 1);
  localparam logic [JAM_W-1:0] JAM_MAX  = JAM_W'(JAM_CYCLES);
  localparam logic [JAM_W-1:0] JAM_LAST = JAM_W'(JAM_CYCLES - 1);

  logic [JAM_W-1:0] jam_cnt_q;
  logic             jam_q;

  // Jam timer runs only in HOLD; the flag is sticky until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jam_cnt_q <= '0;
      jam_q     <= 1'b0;
    end else if (state_q == ST_HOLD) begin
      if (jam_cnt_q != JAM_MAX) begin
        jam_cnt_q <= jam_cnt_q + JAM_W'(1);
      end
      if (jam_cnt_q == JAM_LAST) begin
        jam_q <= 1'b1;
      end
    end else begin
      jam_cnt_q <= '0;
    end
  end

  assign jam_o = jam_q;
`endif

endmodule

// File: rtl/coin_detector.sv
// coin_detector: two debounced sensor channels, registered coin pulses and
// conflict arbitration. Define JAM_DETECT_EN to add the sticky jam output.
module coin_detector
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
`ifdef JAM_DETECT_EN
  ,
  parameter int JAM_CYCLES      = JAM_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic nickel_raw,
  input  logic dime_raw,
  output logic n,
  output logic d,
  output logic busy,
  output logic conflict
`ifdef JAM_DETECT_EN
  ,
  output logic jam
`endif
);

  logic qual_n, qual_d;
  logic busy_n, busy_d;
  logic n_q, d_q, conflict_q;
  logic n_d, d_d, conflict_d;

`ifdef JAM_DETECT_EN
  logic jam_n, jam_d;
`endif

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
`ifdef JAM_DETECT_EN
    ,
    .JAM_CYCLES     (JAM_CYCLES)
`endif
  ) u_nickel (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (nickel_raw),
    .qualify_o(qual_n),
    .busy_o   (busy_n)
`ifdef JAM_DETECT_EN
    ,
    .jam_o    (jam_n)
`endif
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
`ifdef JAM_DETECT_EN
    ,
    .JAM_CYCLES     (JAM_CYCLES)
`endif
  ) u_dime (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (dime_raw),
    .qualify_o(qual_d),
    .busy_o   (busy_d)
`ifdef JAM_DETECT_EN
    ,
    .jam_o    (jam_d)
`endif
  );

  // Arbitration: same-cycle qualifies suppress both coins and flag a conflict
  always_comb begin
    n_d        = qual_n & ~qual_d;
    d_d        = qual_d & ~qual_n;
    conflict_d = qual_n & qual_d;
  end

  // Registered single-cycle output pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q        <= 1'b0;
      d_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      n_q        <= n_d;
      d_q        <= d_d;
      conflict_q <= conflict_d;
    end
  end

  assign n        = n_q;
  assign d        = d_q;
  assign conflict = conflict_q;
  assign busy     = busy_n | busy_d;

`ifdef JAM_DETECT_EN
  assign jam = jam_n | jam_d;
`endif

endmodule

// File: tb/tb_coin_detector.sv
// tb_coin_detector: directed vectors for coin_detector with hand-computed
// pulse positions. Edge indices restart at 1 for each scenario; the raw
// value applied in step i is first sampled by the clock edge numbered i.
`timescale 1ns/1ps
module tb_coin_detector;

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic nickel_raw = 1'b0;
  logic dime_raw   = 1'b0;
  logic n, d, busy, conflict;
`ifdef JAM_DETECT_EN
  logic jam;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  int   e;
  int   n_rise, n_hi, n_first;
  int   d_rise, d_hi, d_first;
  int   c_rise, c_hi, c_first;
  int   b_hi, b_first, b_last;
  int   j_first;
  logic n_prev, d_prev, c_prev;

  coin_detector #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
`ifdef JAM_DETECT_EN
    ,
    .JAM_CYCLES     (16)
`endif
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .nickel_raw(nickel_raw),
    .dime_raw  (dime_raw),
    .n         (n),
    .d         (d),
    .busy      (busy),
    .conflict  (conflict)
`ifdef JAM_DETECT_EN
    ,
    .jam       (jam)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    e = 0;
    n_rise = 0; n_hi = 0; n_first = -1;
    d_rise = 0; d_hi = 0; d_first = -1;
    c_rise = 0; c_hi = 0; c_first = -1;
    b_hi = 0; b_first = -1; b_last = -1;
    j_first = -1;
    n_prev = 1'b0; d_prev = 1'b0; c_prev = 1'b0;
  endtask

  task automatic step(input logic nr, input logic dr);
    nickel_raw = nr;
    dime_raw   = dr;
    @(posedge clk);
    #1;
    e++;
    if (n) begin
      n_hi++;
      if (!n_prev) begin n_rise++; if (n_first < 0) n_first = e; end
    end
    if (d) begin
      d_hi++;
      if (!d_prev) begin d_rise++; if (d_first < 0) d_first = e; end
    end
    if (conflict) begin
      c_hi++;
      if (!c_prev) begin c_rise++; if (c_first < 0) c_first = e; end
    end
    if (busy) begin
      b_hi++;
      if (b_first < 0) b_first = e;
      b_last = e;
    end
`ifdef JAM_DETECT_EN
    if (jam && j_first < 0) j_first = e;
`endif
    n_prev = n;
    d_prev = d;
    c_prev = conflict;
  endtask

  task automatic drive(input logic nr, input logic dr, input int cyc);
    for (int i = 0; i < cyc; i++) step(nr, dr);
  endtask

  initial begin
    clear_stats();

    // Reset with a live sensor line: nothing may move
    reset_n  = 1'b0;
    dime_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_n", int'(n), 0);
    check_eq("rst_d", int'(d), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_conflict", int'(conflict), 0);
`ifdef JAM_DETECT_EN
    check_eq("rst_jam", int'(jam), 0);
`endif
    dime_raw = 1'b0;
    reset_n  = 1'b1;

    // Idle
    clear_stats();
    drive(0, 0, 20);
    check_eq("idle_n", n_hi, 0);
    check_eq("idle_d", d_hi, 0);
    check_eq("idle_conflict", c_hi, 0);
    check_eq("idle_busy", b_hi, 0);

    // Clean nickel: 12 high, then low
    clear_stats();
    drive(1, 0, 12);
    drive(0, 0, 10);
    check_eq("clean_n_pulses", n_rise, 1);
    check_eq("clean_n_width", n_hi, 1);
    check_eq("clean_n_edge", n_first, 6);
    check_eq("clean_d", d_hi, 0);
    check_eq("clean_busy_first", b_first, 3);
    check_eq("clean_busy_last", b_last, 17);
    check_eq("clean_idle", int'(busy), 0);

    // Bounced dime with release bounce
    clear_stats();
    step(0, 1); step(0, 1); step(0, 0); step(0, 1);
    drive(0, 1, 10);
    step(0, 0); step(0, 1); step(0, 0);
    drive(0, 0, 10);
    check_eq("bounce_d_pulses", d_rise, 1);
    check_eq("bounce_d_width", d_hi, 1);
    check_eq("bounce_d_edge", d_first, 9);
    check_eq("bounce_n", n_hi, 0);
    check_eq("bounce_busy_last", b_last, 21);

    // Glitch: 3 high cycles rejected
    clear_stats();
    drive(1, 0, 3);
    drive(0, 0, 10);
    check_eq("glitch_n", n_hi, 0);
    check_eq("glitch_busy_cnt", b_hi, 3);
    check_eq("glitch_idle", int'(busy), 0);

    // Minimum accepted width: exactly 4 high cycles
    clear_stats();
    drive(1, 0, 4);
    drive(0, 0, 12);
    check_eq("min_n_pulses", n_rise, 1);
    check_eq("min_n_edge", n_first, 6);
    check_eq("min_busy_last", b_last, 9);

    // Simultaneous coins
    clear_stats();
    drive(1, 1, 10);
    drive(0, 0, 12);
    check_eq("simul_conflict_pulses", c_rise, 1);
    check_eq("simul_conflict_width", c_hi, 1);
    check_eq("simul_conflict_edge", c_first, 6);
    check_eq("simul_n", n_hi, 0);
    check_eq("simul_d", d_hi, 0);
    check_eq("simul_busy_last", b_last, 15);

    // Reset mid-ARM, coin gone by release: no pulse
    clear_stats();
    drive(1, 0, 4);
    check_eq("midarm_busy_pre", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_eq("midarm_busy_rst", int'(busy), 0);
    drive(0, 0, 2);
    reset_n = 1'b1;
    drive(0, 0, 12);
    check_eq("midarm_n", n_hi, 0);

    // Raw held high through reset release: fresh insertion
    drive(1, 0, 3);
    reset_n = 1'b0;
    drive(1, 0, 2);
    reset_n = 1'b1;
    clear_stats();
    drive(1, 0, 10);
    drive(0, 0, 10);
    check_eq("thru_rst_n_pulses", n_rise, 1);
    check_eq("thru_rst_n_edge", n_first, 6);

`ifdef JAM_DETECT_EN
    // Jam: HOLD entered at edge 6, jam expected at edge 22
    clear_stats();
    drive(1, 0, 40);
    check_eq("jam_n_pulses", n_rise, 1);
    check_eq("jam_edge", j_first, 22);
    drive(0, 0, 10);
    check_eq("jam_sticky", int'(jam), 1);
    check_eq("jam_busy_idle", int'(busy), 0);
    reset_n = 1'b0;
    #1;
    check_eq("jam_cleared", int'(jam), 0);
    reset_n = 1'b1;
    drive(0, 0, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
